// File: rtl/sprite_bram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// sprite_bram_arbiter_pkg : shared constants and id-width helper
// Rev 1.0
// ============================================================================
package sprite_bram_arbiter_pkg;

  localparam int STATS_W              = 16;
  localparam int BRAM_LATENCY_DEFAULT = 2;

  // Never returns less than 1 so a one-bit id field always exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_bram_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, search starts after last
// Rev 1.0
// ============================================================================
module rr_arbiter
  import sprite_bram_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx
);

  logic           found;
  logic [IDW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = IDW'((int'(last) + k) % N);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_bram_arbiter.sv
`default_nettype none
// ============================================================================
// sprite_bram_arbiter : round-robin share of one sprite BRAM read port
// Optional per-frame contention stats: SPRITE_ARB_STATS_EN.   Rev 1.0
// ============================================================================
module sprite_bram_arbiter
  import sprite_bram_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 1,
  parameter int BRAM_LATENCY = BRAM_LATENCY_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_adr,
  output logic [NUM_REQ-1:0]        grant,
  output logic [ADDR_W-1:0]         bram_adr,
  input  logic [DATA_W-1:0]         bram_dout,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      vsync,
  output logic [STATS_W-1:0]        conflict_count
);

  localparam int ID_W  = clog2(NUM_REQ);
  localparam int DEPTH = BRAM_LATENCY + 1;

  logic [NUM_REQ-1:0]          arb_grant;
  logic [ID_W-1:0]             win_idx;
  logic                        granted;
  logic [ID_W-1:0]             last_q, last_d;
  logic [ADDR_W-1:0]           bram_adr_q, bram_adr_d;
  logic [DEPTH-1:0]            pv_q, pv_d;
  logic [DEPTH-1:0][ID_W-1:0]  pid_q, pid_d;
  logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]           rsp_data_q, rsp_data_d;

  rr_arbiter #(.N(NUM_REQ), .IDW(ID_W)) u_rr_arbiter (
    .req   (req),
    .last  (last_q),
    .grant (arb_grant),
    .idx   (win_idx)
  );

  // Held in reset, nothing may be accepted even though req is live.
  assign grant   = reset_n ? arb_grant : '0;
  assign granted = |grant;

  always_comb begin
    last_d      = granted ? win_idx : last_q;
    bram_adr_d  = granted ? req_adr[win_idx*ADDR_W +: ADDR_W] : '0;
    pv_d        = {pv_q[DEPTH-2:0], granted};
    pid_d       = {pid_q[DEPTH-2:0], win_idx};
    rsp_valid_d = pv_q[DEPTH-1] ? (NUM_REQ'(1) << pid_q[DEPTH-1]) : '0;
    rsp_data_d  = pv_q[DEPTH-1] ? bram_dout : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q      <= ID_W'(NUM_REQ - 1);
      bram_adr_q  <= '0;
      pv_q        <= '0;
      pid_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      last_q      <= last_d;
      bram_adr_q  <= bram_adr_d;
      pv_q        <= pv_d;
      pid_q       <= pid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bram_adr  = bram_adr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef SPRITE_ARB_STATS_EN
  logic               vsync_q, vsync_d;
  logic [STATS_W-1:0] cnt_q, cnt_d;
  logic [STATS_W-1:0] cc_q, cc_d;
  logic               conflict;

  // The frame boundary cycle itself seeds the new frame's count.
  always_comb begin
    vsync_d  = vsync;
    conflict = ($countones(req) >= 2);
    cnt_d    = cnt_q;
    cc_d     = cc_q;
    if (vsync && !vsync_q) begin
      cc_d  = cnt_q;
      cnt_d = conflict ? STATS_W'(1) : '0;
    end else if (conflict && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
      cnt_q   <= '0;
      cc_q    <= '0;
    end else begin
      vsync_q <= vsync_d;
      cnt_q   <= cnt_d;
      cc_q    <= cc_d;
    end
  end

  assign conflict_count = cc_q;
`else
  logic unused_vsync;
  assign unused_vsync   = vsync;
  assign conflict_count = '0;
`endif

endmodule
`default_nettype wire
